// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: TinyRV1 word width, memory
// request type encodings and the arbiter FSM state type.
package mem_arbiter_pkg;

  // TinyRV1 machine word width
  localparam int unsigned XLEN = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWaitI = 2'd1,
    StWaitD = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported memory: one outstanding transaction,
// data priority with a starvation limit, combinational request/response routing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned p_starve_limit = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            imemreq_val,
  output logic            imemreq_rdy,
  input  logic [XLEN-1:0] imemreq_addr,
  output logic            imemresp_val,
  output logic [XLEN-1:0] imemresp_data,

  input  logic            dmemreq_val,
  output logic            dmemreq_rdy,
  input  logic            dmemreq_type,
  input  logic [XLEN-1:0] dmemreq_addr,
  input  logic [XLEN-1:0] dmemreq_wdata,
  output logic            dmemresp_val,
  output logic [XLEN-1:0] dmemresp_data,

  output logic            memreq_val,
  input  logic            memreq_rdy,
  output logic            memreq_type,
  output logic [XLEN-1:0] memreq_addr,
  output logic [XLEN-1:0] memreq_wdata,
  input  logic            memresp_val,
  input  logic [XLEN-1:0] memresp_data
);

  localparam logic [2:0] Limit = 3'(p_starve_limit);

  state_e     state_q, state_d;
  logic [2:0] starve_q, starve_d;
  logic       arb_en, grant_i, grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    imemreq_rdy   = 1'b0;
    imemresp_val  = 1'b0;
    imemresp_data = '0;
    dmemreq_rdy   = 1'b0;
    dmemresp_val  = 1'b0;
    dmemresp_data = '0;
    memreq_val    = 1'b0;
    memreq_type   = MEM_READ;
    memreq_addr   = '0;
    memreq_wdata  = '0;

    // A returning response frees the port, so a new grant can share its cycle.
    arb_en = (state_q == StIdle) || memresp_val;

    case (state_q)
      StWaitI: begin
        imemresp_val  = memresp_val;
        imemresp_data = memresp_val ? memresp_data : '0;
      end
      StWaitD: begin
        dmemresp_val  = memresp_val;
        dmemresp_data = memresp_val ? memresp_data : '0;
      end
      default: ;
    endcase

    if (arb_en) begin
      if (imemreq_val && (starve_q == Limit)) grant_i = 1'b1;
      else if (dmemreq_val)                   grant_d = 1'b1;
      else if (imemreq_val)                   grant_i = 1'b1;
    end

    if (grant_d) begin
      memreq_val   = 1'b1;
      memreq_type  = dmemreq_type;
      memreq_addr  = dmemreq_addr;
      memreq_wdata = dmemreq_wdata;
      dmemreq_rdy  = memreq_rdy;
    end else if (grant_i) begin
      memreq_val  = 1'b1;
      memreq_addr = imemreq_addr;
      imemreq_rdy = memreq_rdy;
    end

    if (arb_en) begin
      if (grant_i && memreq_rdy)      state_d = StWaitI;
      else if (grant_d && memreq_rdy) state_d = StWaitD;
      else                            state_d = StIdle;
    end

    if (grant_i && memreq_rdy) begin
      starve_d = 3'd0;
    end else if (grant_d && memreq_rdy && imemreq_val && (starve_q != Limit)) begin
      starve_d = starve_q + 3'd1;
    end

    // Outputs stay quiet for the whole reset pulse, not just until the next edge.
    if (rst) begin
      imemreq_rdy   = 1'b0;
      imemresp_val  = 1'b0;
      imemresp_data = '0;
      dmemreq_rdy   = 1'b0;
      dmemresp_val  = 1'b0;
      dmemresp_data = '0;
      memreq_val    = 1'b0;
      memreq_type   = MEM_READ;
      memreq_addr   = '0;
      memreq_wdata  = '0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single-ported unified memory between the TinyRV1 pipeline's instruction fetch port (F stage) and data port (M stage). Accepts at most one outstanding memory transaction and routes each response back to the requester that issued it. Data requests win by default; a starvation counter guarantees fetch progress under sustained load/store traffic. Sits between the processor's imem/dmem ports and the memory model or SRAM wrapper.

## Interface
- p_starve_limit, 4, consecutive data grants tolerated while a fetch is pending before fetch is forced; valid range 1..7.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imemreq_val  in  1  fetch request valid.
- imemreq_rdy  out  1  fetch request accepted this cycle.
- imemreq_addr  in  32  fetch byte address.
- imemresp_val  out  1  fetch response valid.
- imemresp_data  out  32  fetched instruction.
- dmemreq_val  in  1  data request valid.
- dmemreq_rdy  out  1  data request accepted this cycle.
- dmemreq_type  in  1  0 = read, 1 = write.
- dmemreq_addr  in  32  data byte address.
- dmemreq_wdata  in  32  store data.
- dmemresp_val  out  1  data response valid (reads and write acks).
- dmemresp_data  out  32  load data; don't-care for write acks.
- memreq_val  out  1  request to memory.
- memreq_rdy  in  1  memory accepts request.
- memreq_type  out  1  0 = read, 1 = write; fetches always 0.
- memreq_addr  out  32  forwarded address.
- memreq_wdata  out  32  forwarded store data; 0 for fetches.
- memresp_val  in  1  memory response valid.
- memresp_data  in  32  memory response data.

## Operation
- FSM states: IDLE (no outstanding transaction), WAIT_I (fetch outstanding), WAIT_D (data outstanding). Reset state IDLE; starvation counter resets to 0.
- Arbitration (performed in IDLE, and in WAIT_x in the cycle memresp_val=1):
  - Fetch forced if imemreq_val and starve count == p_starve_limit.
  - Otherwise dmem wins if dmemreq_val; else imem if imemreq_val; else no request.
- Winner's fields are driven onto memreq_*, memreq_val=1; winner's rdy = memreq_rdy; loser's rdy = 0.
- Handshake (memreq_val & memreq_rdy) moves to WAIT_D or WAIT_I. Without handshake, state unchanged, and arbitration is recomputed next cycle; request fields need not be held stable.
- In WAIT_x without memresp_val: memreq_val=0, both rdy=0.
- Response: in WAIT_I, memresp_val drives imemresp_val=1, imemresp_data=memresp_data; WAIT_D likewise for dmem. Non-owner resp_val=0. Next state follows the same-cycle arbitration (WAIT_x on new handshake, else IDLE).
- memresp_val in IDLE: ignored, no response emitted.
- Starvation counter: on a data-grant handshake while imemreq_val=1, increment (saturate at p_starve_limit); on any fetch-grant handshake, clear to 0; otherwise hold.
- Reset mid-transaction: outstanding transaction abandoned; the memory side is reset in the same event.

## Timing
- Request path combinational: zero-cycle latency from *req_val to memreq_val.
- Response path combinational: zero-cycle latency from memresp_val to *resp_val.
- memresp_val is never expected in the same cycle as its own request handshake; minimum round trip 1 cycle.
- Throughput: one transaction per cycle when memory responds next cycle, via grant-on-response.
- While rst=1: all val and rdy outputs 0; data outputs 0.

## Structure
- Shared package: FSM state enum (IDLE, WAIT_I, WAIT_D) and memory type constants MEM_READ=0, MEM_WRITE=1, alongside the TinyRV1 definitions.
- No sub-module: state and starvation counter held in local always_ff registers with asynchronous reset; arbitration and routing in one always_comb.

## Test plan
- Fetch only: imemreq addr 0x200, memreq_rdy=1, memresp next cycle data 0x00000013 -> imemresp_val=1, data 0x00000013, dmemresp_val=0, state back to IDLE.
- Simultaneous: both val, dmem write addr 0x1000 wdata 0xDEADBEEF -> memreq_type=1, dmemreq_rdy=1, imemreq_rdy=0; fetch granted in cycle of write ack.
- Back-to-back: three fetches 0x0,0x4,0x8 with memory responding each next cycle -> three imemresp_val pulses on consecutive cycles.
- Starvation: dmemreq_val held high, imemreq_val high, p_starve_limit=4 -> 4 data grants, then 5th grant is fetch, counter returns to 0.
- Backpressure: memreq_rdy=0 for 3 cycles with dmem read pending -> dmemreq_rdy=0, state IDLE; grant on 4th cycle.
- Reset in WAIT_D then memresp_val=1 after release -> no dmemresp_val or imemresp_val; state IDLE.
